fifo_pkt_framer: RTL and testbench

FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

---
 rtl/fifo_pkt_framer.sv | 121 ++++++++++++
 tb/tb_fifo_pkt_framer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_framer.sv
// Packet framer: drains a show-ahead FIFO into SYNC / payload / LEN / CHK packets,
// closing a packet at MAX_LEN words or after IDLE_TO consecutive empty cycles.
// Handshake: a word transfers when m_valid & m_ready at a rising edge; while m_valid
// is high and m_ready is low, m_data/m_sof/m_eof hold their values.
module fifo_pkt_framer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter int                    IDLE_TO    = 32,
  parameter logic [DATA_WIDTH-1:0] SYNC       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  pkt_done,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(IDLE_TO + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_LEN  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic [DATA_WIDTH-1:0] chk, chk_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  done_nxt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      chk      <= '0;
      timer    <= '0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      chk      <= chk_nxt;
      timer    <= timer_nxt;
      pkt_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    chk_nxt    = chk;
    timer_nxt  = timer;
    done_nxt   = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_sof      = 1'b0;
    m_eof      = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_HDR;
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = SYNC;
        m_sof   = 1'b1;
        if (m_ready) begin
          state_nxt = S_PAY;
          count_nxt = '0;
          chk_nxt   = '0;
          timer_nxt = '0;
        end
      end
      S_PAY: begin
        m_valid    = !fifo_empty;
        m_data     = fifo_dout;
        fifo_rd_en = !fifo_empty && m_ready;
        if (fifo_rd_en) begin
          count_nxt = count + CW'(1);
          chk_nxt   = chk ^ fifo_dout;
          timer_nxt = '0;
          if (count_nxt == MAX_CNT) state_nxt = S_LEN;
        end else if (fifo_empty) begin
          // A stalled but non-empty FIFO leaves the timer alone.
          if (timer == TO_LAST) state_nxt = S_LEN;
          else                  timer_nxt = timer + TW'(1);
        end
      end
      S_LEN: begin
        m_valid = 1'b1;
        m_data  = DATA_WIDTH'(count);
        if (m_ready) state_nxt = S_CHK;
      end
      S_CHK: begin
        m_valid = 1'b1;
        m_data  = chk;
        m_eof   = 1'b1;
        if (m_ready) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed bench for fifo_pkt_framer: queue-based FIFO model, packet-level scoreboard
// checked every cycle, plus literal expectations for the packets of each scenario.
module tb_fifo_pkt_framer;

  localparam int DW      = 8;
  localparam int MAX_LEN = 16;
  localparam int IDLE_TO = 32;
  localparam int EW      = DW + 3;
  localparam int K_HDR   = 0;
  localparam int K_PAY   = 1;
  localparam int K_LEN   = 2;
  localparam int K_CHK   = 3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sof;
  logic          m_eof;
  logic          pkt_done;
  logic [2:0]    dbg_state;

  fifo_pkt_framer #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (MAX_LEN),
    .IDLE_TO   (IDLE_TO),
    .SYNC      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .pkt_done  (pkt_done),
    .dbg_state (dbg_state)
  );

  // model state: upstream FIFO contents and expected stream {imm, kind, data}
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pkt_words[$];
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] obs_len_q[$];
  logic [DW-1:0] obs_chk_q[$];
  int checks = 0;
  int errors = 0;
  int phase, empty_run, pops, done_count, eof_cyc, test_cyc, ready_mode;
  bit idle_armed, done_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int kind, input bit imm, input logic [DW-1:0] d);
    return {imm, 2'(kind), d};
  endfunction

  // A packet is SYNC, the payload, its word count, and the XOR of the payload.
  task automatic add_packet();
    logic [DW-1:0] x;
    x = '0;
    exp_q.push_back(mk(K_HDR, 1'b0, 8'hA5));
    foreach (pkt_words[i]) begin
      exp_q.push_back(mk(K_PAY, 1'b0, pkt_words[i]));
      x = x ^ pkt_words[i];
    end
    exp_q.push_back(mk(K_LEN, pkt_words.size() == MAX_LEN, DW'(pkt_words.size())));
    exp_q.push_back(mk(K_CHK, 1'b0, x));
    pkt_words.delete();
  endtask

  // scoreboard: called once per cycle, away from the rising edge
  task automatic compare();
    logic [EW-1:0] head;
    int kind;
    bit exp_valid, hs;
    head = '0;
    kind = -1;
    exp_valid = 1'b0;
    if (phase == 0) begin
      if (idle_armed) begin
        phase = 1;
        idle_armed = 1'b0;
      end else begin
        idle_armed = !fifo_empty;
      end
    end
    if (phase == 1) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 32'(m_valid), 32'd0);
        phase = 0;
      end else begin
        head = exp_q[0];
        kind = int'(head[DW+1:DW]);
        case (kind)
          K_PAY:   exp_valid = !fifo_empty;
          K_LEN:   exp_valid = head[DW+2] || (empty_run >= IDLE_TO);
          default: exp_valid = 1'b1;
        endcase
      end
    end
    hs = exp_valid && m_ready;
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("m_data", 32'(m_data), 32'(head[DW-1:0]));
      check("m_sof", 32'(m_sof), 32'(kind == K_HDR));
      check("m_eof", 32'(m_eof), 32'(kind == K_CHK));
    end else begin
      check("sof_eof_when_invalid", 32'({m_sof, m_eof}), 32'd0);
    end
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(hs && kind == K_PAY));
    check("pkt_done", 32'(pkt_done), 32'(done_prev));
    if (pkt_done) done_count++;
    done_prev = 1'b0;
    if (hs) begin
      void'(exp_q.pop_front());
      empty_run = 0;
      if (kind == K_PAY) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      if (kind == K_LEN) obs_len_q.push_back(m_data);
      if (kind == K_CHK) begin
        obs_chk_q.push_back(m_data);
        phase = 0;
        done_prev = 1'b1;
        eof_cyc = test_cyc;
      end
    end else if (phase == 1 && fifo_empty) begin
      empty_run++;
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic tick();
    @(negedge clk);
    test_cyc++;
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? DW'($urandom_range(0, 255)) : fifo_q[0];
    case (ready_mode)
      1:       m_ready = (test_cyc % 2 == 0);
      2:       m_ready = !(test_cyc >= 3 && test_cyc < 43);
      default: m_ready = 1'b1;
    endcase
    #1;
    compare();
  endtask

  task automatic run_pkts(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || phase != 0 || done_prev) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words outstanding, expected 0 within %0d cycles",
               name, exp_q.size(), budget);
      exp_q.delete();
      phase = 0;
      done_prev = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    m_ready    = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_sof_eof", 32'({m_sof, m_eof}), 32'd0);
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    phase      = 0;
    idle_armed = 1'b0;
    empty_run  = 0;
    done_prev  = 1'b0;
  endtask

  task automatic begin_test(input int mode);
    ready_mode = mode;
    test_cyc   = 0;
    pops       = 0;
    done_count = 0;
    eof_cyc    = -1;
    obs_len_q.delete();
    obs_chk_q.delete();
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(fifo_rd_en && fifo_empty)) else $error("fifo_rd_en asserted with empty FIFO");
      assert (!fifo_rd_en || dbg_state == 3'd2) else $error("fifo_rd_en outside payload state");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    m_ready    = 1'b0;
    begin_test(0);
    do_reset();

    // three words, then the idle timeout closes the packet
    begin_test(0);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h07); fifo_q.push_back(8'h09);
    pkt_words.push_back(8'h03); pkt_words.push_back(8'h07); pkt_words.push_back(8'h09);
    add_packet();
    run_pkts("t_timeout", 200);
    check("t1_pops", 32'(pops), 32'd3);
    check("t1_pkt_done_pulses", 32'(done_count), 32'd1);
    check("t1_eof_cycle", 32'(eof_cyc), 32'd39);
    check("t1_len", 32'(obs_len_q.size() > 0 ? obs_len_q[0] : 8'hxx), 32'h03);
    check("t1_chk", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h0D);

    // 20 words: one full packet, then a short one back to back
    begin_test(0);
    for (int i = 1; i <= 20; i++) fifo_q.push_back(DW'(i));
    for (int i = 1; i <= 16; i++) pkt_words.push_back(DW'(i));
    add_packet();
    for (int i = 17; i <= 20; i++) pkt_words.push_back(DW'(i));
    add_packet();
    run_pkts("t_maxlen", 300);
    check("t2_pops", 32'(pops), 32'd20);
    check("t2_npkts", 32'(obs_chk_q.size()), 32'd2);
    check("t2_len0", 32'(obs_len_q.size() > 0 ? obs_len_q[0] : 8'hxx), 32'h10);
    check("t2_chk0", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h10);
    check("t2_len1", 32'(obs_len_q.size() > 1 ? obs_len_q[1] : 8'hxx), 32'h04);
    check("t2_chk1", 32'(obs_chk_q.size() > 1 ? obs_chk_q[1] : 8'hxx), 32'h04);

    // m_ready toggling every cycle
    begin_test(1);
    for (int i = 0; i < 6; i++) begin
      fifo_q.push_back(DW'(8'h20 + i));
      pkt_words.push_back(DW'(8'h20 + i));
    end
    add_packet();
    run_pkts("t_toggle", 300);
    check("t3_pops", 32'(pops), 32'd6);
    check("t3_len", 32'(obs_len_q.size() > 0 ? obs_len_q[0] : 8'hxx), 32'h06);
    check("t3_chk", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h01);

    // 40-cycle stall with data waiting must not time out
    begin_test(2);
    fifo_q.push_back(8'h31); fifo_q.push_back(8'h32); fifo_q.push_back(8'h33);
    pkt_words.push_back(8'h31); pkt_words.push_back(8'h32); pkt_words.push_back(8'h33);
    add_packet();
    run_pkts("t_stall", 300);
    check("t4_pops", 32'(pops), 32'd3);
    check("t4_npkts", 32'(obs_chk_q.size()), 32'd1);
    check("t4_chk", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h30);

    // gap of IDLE_TO-1 empty cycles keeps the packet open
    begin_test(0);
    fifo_q.push_back(8'h55);
    pkt_words.push_back(8'h55); pkt_words.push_back(8'h66);
    add_packet();
    repeat (3) tick();
    check("t5_first_pop", 32'(pops), 32'd1);
    repeat (IDLE_TO - 1) tick();
    fifo_q.push_back(8'h66);
    run_pkts("t_gap", 200);
    check("t5_npkts", 32'(obs_chk_q.size()), 32'd1);
    check("t5_len", 32'(obs_len_q.size() > 0 ? obs_len_q[0] : 8'hxx), 32'h02);
    check("t5_chk", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h33);

    // reset after two payload words abandons the packet
    begin_test(0);
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(DW'(8'h41 + i));
      pkt_words.push_back(DW'(8'h41 + i));
    end
    add_packet();
    repeat (4) tick();
    check("t6_pops_before_reset", 32'(pops), 32'd2);
    do_reset();
    begin_test(0);
    pkt_words.push_back(8'h43); pkt_words.push_back(8'h44);
    add_packet();
    run_pkts("t_reset", 200);
    check("t6_npkts", 32'(obs_chk_q.size()), 32'd1);
    check("t6_len", 32'(obs_len_q.size() > 0 ? obs_len_q[0] : 8'hxx), 32'h02);
    check("t6_chk", 32'(obs_chk_q.size() > 0 ? obs_chk_q[0] : 8'hxx), 32'h07);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
